rx_lane_deskew: RTL and testbench

Parametrised multi-lane deskew buffer. It sits between the per-lane descramblers and the lane-merge/LMC stage of the RX path. Each lane is buffered in its own FIFO. Lanes are aligned on a common marker (COM for 8b/10b, EIEOS/SKP block start for 128b/130b). All active lanes are then released in lockstep, and alignment is monitored continuously.

---
 rtl/rx_lane_deskew.sv | 146 ++++++++++++++
 tb/tb_rx_lane_deskew.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/rx_lane_deskew.sv
// rx_lane_deskew: per-lane FIFOs aligned on a common marker, released in lockstep.
// Registered bypass when deskew is disabled; alignment is re-checked on every read.
module rx_lane_deskew #(
    parameter int LANES = 16,
    parameter int SYMW  = 32,
    parameter int DEPTH = 8,
    parameter int PW    = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  deskewEnable,
    input  logic [4:0]            activeLanes,
    input  logic [LANES-1:0]      laneValid,
    input  logic [LANES*SYMW-1:0] laneData,
    input  logic [2*LANES-1:0]    laneSyncHeader,
    input  logic [LANES-1:0]      laneMarker,
    output logic [LANES*SYMW-1:0] deskewData,
    output logic [2*LANES-1:0]    deskewSyncHeader,
    output logic                  deskewValid,
    output logic                  aligned,
    output logic                  skewError,
    output logic [PW:0]           maxSkew
);
    localparam int EW = SYMW + 3;
    typedef enum logic [1:0] {S_SEARCH, S_WAIT, S_ALIGNED} state_t;
    state_t state, state_nx;
    logic [EW-1:0] mem [LANES][DEPTH];
    logic [PW:0] wr_ptr [LANES];
    logic [PW:0] rd_ptr [LANES];
    logic [PW:0] mark_ptr [LANES];
    logic [LANES-1:0] act, rec, wr_en, mark_wr, empty, full, rd_mk;
    logic [PW:0] skew_cnt;
    logic en_q;
    logic [4:0] act_q;
    logic cfg_chg, all_rec, rd_go, mismatch, ovf, err, flush, lock, out_go;
    logic [LANES*SYMW-1:0] rd_data, byp_data;
    logic [2*LANES-1:0] rd_sh, byp_sh;

    always_comb begin
        act = '0;
        wr_en = '0;
        mark_wr = '0;
        empty = '0;
        full = '0;
        rd_mk = '0;
        rd_data = '0;
        rd_sh = '0;
        byp_data = '0;
        byp_sh = '0;
        for (int i = 0; i < LANES; i++) begin
            act[i] = i < int'(activeLanes);
            wr_en[i] = laneValid[i] & act[i];
            mark_wr[i] = wr_en[i] & laneMarker[i];
            empty[i] = rd_ptr[i] == wr_ptr[i];
            full[i] = (rd_ptr[i] ^ wr_ptr[i]) == {1'b1, {PW{1'b0}}};
            rd_mk[i] = mem[i][rd_ptr[i][PW-1:0]][EW-1];
            rd_data[i*SYMW +: SYMW] = act[i] ? mem[i][rd_ptr[i][PW-1:0]][SYMW-1:0] : '0;
            rd_sh[2*i +: 2] = act[i] ? mem[i][rd_ptr[i][PW-1:0]][SYMW +: 2] : '0;
            byp_data[i*SYMW +: SYMW] = act[i] ? laneData[i*SYMW +: SYMW] : '0;
            byp_sh[2*i +: 2] = act[i] ? laneSyncHeader[2*i +: 2] : '0;
        end
    end

    always_comb begin
        cfg_chg = deskewEnable != en_q || activeLanes != act_q;
        all_rec = &(rec | ~act);
        rd_go = state == S_ALIGNED && (empty & act) == '0;
        mismatch = rd_go && (rd_mk & act) != '0 && (~rd_mk & act) != '0;
        ovf = state == S_ALIGNED && !rd_go && (wr_en & full) != '0;
        // A configuration change restarts alignment silently; it never reports an error.
        err = deskewEnable && !cfg_chg &&
              ((state == S_WAIT && skew_cnt == (PW+1)'(DEPTH-2)) || mismatch || ovf);
        flush = !deskewEnable || cfg_chg || err;
        lock = !flush && state == S_WAIT && all_rec;
        out_go = rd_go && !flush;
    end

    always_comb begin
        state_nx = state;
        state_nx = flush ? S_SEARCH :
                   lock ? S_ALIGNED :
                   (state == S_SEARCH && mark_wr != '0) ? S_WAIT : state;
    end

    assign aligned = state == S_ALIGNED;

    always_ff @(posedge clk)
        for (int i = 0; i < LANES; i++)
            if (wr_en[i] && !flush)
                mem[i][wr_ptr[i][PW-1:0]] <= {laneMarker[i], laneSyncHeader[2*i +: 2], laneData[i*SYMW +: SYMW]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_SEARCH;
            en_q <= 1'b0;
            act_q <= '0;
            rec <= '0;
            skew_cnt <= '0;
            maxSkew <= '0;
            skewError <= 1'b0;
            deskewValid <= 1'b0;
            deskewData <= '0;
            deskewSyncHeader <= '0;
            for (int i = 0; i < LANES; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                mark_ptr[i] <= '0;
            end
        end else begin
            state <= state_nx;
            en_q <= deskewEnable;
            act_q <= activeLanes;
            skewError <= err;
            deskewValid <= deskewEnable ? out_go : &(laneValid | ~act);
            if (!deskewEnable) begin
                deskewData <= byp_data;
                deskewSyncHeader <= byp_sh;
            end else if (out_go) begin
                deskewData <= rd_data;
                deskewSyncHeader <= rd_sh;
            end
            if (!deskewEnable)
                maxSkew <= '0;
            else if (lock)
                maxSkew <= skew_cnt;
            skew_cnt <= state == S_WAIT ? skew_cnt + 1'b1 : '0;
            rec <= (flush || state == S_ALIGNED) ? '0 : rec | mark_wr;
            for (int i = 0; i < LANES; i++) begin
                if (flush) begin
                    wr_ptr[i] <= '0;
                    rd_ptr[i] <= '0;
                end else begin
                    if (wr_en[i])
                        wr_ptr[i] <= wr_ptr[i] + 1'b1;
                    // Only the first marker per lane defines where that lane's stream starts.
                    if (mark_wr[i] && !rec[i] && state != S_ALIGNED)
                        mark_ptr[i] <= wr_ptr[i];
                    if (lock)
                        rd_ptr[i] <= mark_ptr[i];
                    else if (out_go)
                        rd_ptr[i] <= rd_ptr[i] + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_rx_lane_deskew.sv
// tb_rx_lane_deskew: directed stimulus for rx_lane_deskew with four active lanes.
// Lane k carries {k, seq}; markers sit on every seq multiple of 16.
module tb_rx_lane_deskew;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic en = 1'b1;
    logic [4:0] act_n = 5'd4;
    logic [15:0] lv = '0;
    logic [511:0] ld = '0;
    logic [31:0] lsh = '0;
    logic [15:0] lm = '0;
    logic [511:0] dd;
    logic [31:0] dsh;
    logic dv, al, se;
    logic [3:0] ms;
    int dly [4];
    int errors = 0;
    int checks = 0;

    rx_lane_deskew dut (
        .clk(clk), .reset(reset), .deskewEnable(en), .activeLanes(act_n),
        .laneValid(lv), .laneData(ld), .laneSyncHeader(lsh), .laneMarker(lm),
        .deskewData(dd), .deskewSyncHeader(dsh), .deskewValid(dv),
        .aligned(al), .skewError(se), .maxSkew(ms)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int t);
        int s;
        lv = '0; lm = '0; ld = '0; lsh = '0;
        for (int k = 0; k < 4; k++) begin
            s = t - dly[k];
            lv[k] = 1'b1;
            ld[k*32 +: 32] = {16'(k), 16'(s)};
            lsh[2*k +: 2] = 2'(s);
            lm[k] = s >= 0 && s % 16 == 0;
        end
    endtask

    task automatic run(input int from, input int to);
        for (int t = from; t <= to; t++) begin
            drive(t);
            tick();
        end
    endtask

    function automatic logic [511:0] ev(input int a, input int b, input int c, input int d);
        int s [4];
        s = '{a, b, c, d};
        ev = '0;
        for (int k = 0; k < 4; k++)
            ev[k*32 +: 32] = {16'(k), 16'(s[k])};
    endfunction

    function automatic logic [511:0] esh(input int s);
        esh = '0;
        for (int k = 0; k < 4; k++)
            esh[2*k +: 2] = 2'(s);
    endfunction

    initial begin
        dly = '{0, 0, 0, 0};
        tick();
        tick();
        chk("rst_data", dd, '0);
        chk("rst_valid", dv, 0);
        chk("rst_aligned", al, 0);
        chk("rst_err", se, 0);
        chk("rst_maxskew", ms, 0);
        reset = 1'b0;
        tick();

        // Zero skew lock, then lane 2 slips by one word
        run(-3, 0);
        chk("z_pre_aligned", al, 0);
        drive(1); tick();
        chk("z_aligned", al, 1);
        chk("z_maxskew", ms, 0);
        chk("z_valid0", dv, 0);
        for (int t = 2; t <= 7; t++) begin
            drive(t); tick();
            chk($sformatf("z_data_t%0d", t), dd, ev(t-2, t-2, t-2, t-2));
            chk($sformatf("z_sh_t%0d", t), dsh, esh(t-2));
            chk($sformatf("z_valid_t%0d", t), dv, 1);
        end
        dly[2] = 1;
        run(8, 9);
        drive(10); tick();
        chk("slip_data", dd, ev(8, 8, 7, 8));
        run(11, 17);
        chk("slip_noerr", se, 0);
        chk("slip_valid", dv, 1);
        drive(18); tick();
        chk("slip_err", se, 1);
        chk("slip_aligned", al, 0);
        chk("slip_valid_drop", dv, 0);
        drive(19); tick();
        chk("slip_err_pulse", se, 0);
        run(20, 33);
        chk("relock_pre", al, 0);
        drive(34); tick();
        chk("relock_aligned", al, 1);
        chk("relock_maxskew", ms, 1);
        for (int t = 35; t <= 37; t++) begin
            drive(t); tick();
            chk($sformatf("relock_data_t%0d", t), dd, ev(t-3, t-3, t-3, t-3));
            chk($sformatf("relock_valid_t%0d", t), dv, 1);
        end

        // Bypass
        en = 1'b0;
        lv = 16'h000F; lm = '0; lsh = 32'h5555_5555;
        for (int k = 0; k < 16; k++) ld[k*32 +: 32] = 32'hA5A5_0001;
        tick();
        chk("byp_data", dd[127:0], {4{32'hA5A5_0001}});
        chk("byp_sh", dsh[7:0], 8'h55);
        chk("byp_valid", dv, 1);
        chk("byp_aligned", al, 0);
        chk("byp_maxskew", ms, 0);
        chk("byp_err", se, 0);

        // Lane k skewed by k clocks
        en = 1'b1;
        dly = '{0, 1, 2, 3};
        run(-3, 3);
        chk("sk3_pre", al, 0);
        drive(4); tick();
        chk("sk3_aligned", al, 1);
        chk("sk3_maxskew", ms, 3);
        for (int t = 5; t <= 12; t++) begin
            drive(t); tick();
            chk($sformatf("sk3_data_t%0d", t), dd, ev(t-5, t-5, t-5, t-5));
            chk($sformatf("sk3_valid_t%0d", t), dv, 1);
        end

        // Skew of DEPTH-2 fails, then a clean relock
        en = 1'b0;
        tick();
        en = 1'b1;
        dly = '{0, 0, 0, 6};
        run(-3, 6);
        chk("sk6_noerr", se, 0);
        chk("sk6_pre", al, 0);
        drive(7); tick();
        chk("sk6_err", se, 1);
        chk("sk6_aligned", al, 0);
        dly[3] = 0;
        drive(8); tick();
        chk("sk6_err_pulse", se, 0);
        run(9, 16);
        drive(17); tick();
        chk("sk6_relock", al, 1);
        chk("sk6_maxskew", ms, 0);
        drive(18); tick();
        chk("sk6_data", dd, ev(16, 16, 16, 16));
        chk("sk6_valid", dv, 1);

        // Asynchronous reset mid-stream
        run(19, 20);
        chk("ar_streaming", dv, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_data", dd, '0);
        chk("ar_sh", dsh, '0);
        chk("ar_valid", dv, 0);
        chk("ar_aligned", al, 0);
        tick();
        reset = 1'b0;
        run(21, 23);
        chk("ar_search_aligned", al, 0);
        chk("ar_search_valid", dv, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
